// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_tx_pkg
//  Purpose  : Shared types and helpers for the PISO transmit sequencer.
//             Holds the FSM state encoding and the minimum-counter-width
//             helper used to validate CNT_W at elaboration.
//  Revision : 1.0  initial release
// ============================================================================
package piso_tx_pkg;

    localparam int c_state_w = 2;

    // State names carry an ST_ prefix so they never collide with the GAP
    // parameter of the controller.
    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Smallest counter width able to hold max(width-1, gap).
    function automatic int min_cnt_w(input int width, input int gap);
        int v;
        int w;
        v = ((width - 1) > gap) ? (width - 1) : gap;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (v >= (1 << i)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_core.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_core
//  Purpose  : WIDTH-bit parallel-load, shift-left register. The MSB is the
//             serial output; zeros enter at the LSB. Load wins over shift.
//  Revision : 1.0  initial release
// ============================================================================
module piso_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_shreg;

    // Shift register: synchronous clear, parallel load, or shift toward MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (load) begin
            r_shreg <= din;
        end else if (shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_shreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/piso_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : piso_tx_ctrl
//  Purpose  : Sequencer for the PISO shifter. Accepts words over valid/ready,
//             serialises them MSB-first with frame_start/done markers, and
//             either chains words with no bubble (GAP=0) or inserts GAP idle
//             cycles after each word.
//  Revision : 1.0  initial release
// ============================================================================
module piso_tx_ctrl
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    generate
        if (WIDTH < 2 || GAP < 0 || GAP > 255 || CNT_W < min_cnt_w(WIDTH, GAP)) begin : g_param_check
            $error("piso_tx_ctrl: WIDTH must be >= 2, GAP in 0..255, CNT_W wide enough for max(WIDTH-1, GAP)");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_first_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last;
    logic             w_ready_st;
    logic             w_xfer;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;

    assign w_last = (r_cnt == '0);

    // Ready is a function of registered state only, so the producer never
    // sees a combinational path from din_valid back to din_ready.
    assign w_ready_st = (r_state == ST_IDLE) ||
                        ((r_state == ST_SHIFT) && w_last && (GAP == 0));
    assign din_ready  = rst_n & w_ready_st;
    assign w_xfer     = din_valid & din_ready;

    // State and counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and shifter control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = c_first_bit;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt - c_one;
                end else if (GAP == 0) begin
                    if (w_xfer) begin
                        // Zero-bubble chaining: reload on the last bit.
                        w_load    = 1'b1;
                        w_cnt_nxt = c_first_bit;
                    end else begin
                        w_shift     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = c_gap_load;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_cnt_nxt = r_cnt - c_one;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .shift (w_shift),
        .din   (din),
        .msb   (w_msb)
    );

    // Serial outputs are decoded purely from registered state/shreg/cnt.
    assign sout_valid  = (r_state == ST_SHIFT);
    assign sout        = sout_valid & w_msb;
    assign frame_start = sout_valid & (r_cnt == c_first_bit);
    assign done        = sout_valid & w_last;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_tx_ctrl
//  Purpose  : Scoreboard bench for piso_tx_ctrl. Index 0 is a WIDTH=4/GAP=0
//             instance, index 1 a WIDTH=4/GAP=3 instance. Accepted words push
//             their expected {sout, frame_start, done} bits into a queue; a
//             negedge monitor pops and compares whenever sout_valid is high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] din [2];
    logic [1:0] dv;
    logic [1:0] rdy;
    logic [1:0] sout;
    logic [1:0] sv;
    logic [1:0] fs;
    logic [1:0] dn;
    logic [1:0] busy;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [2:0] q [2][$];
    int         gapc     [2];
    int         run      [2];
    int         last_run [2];
    logic [1:0] prev_sv;

    logic [3:0] chg_tab [4];

    piso_tx_ctrl #(.WIDTH(4), .GAP(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .sout(sout[0]), .sout_valid(sv[0]),
        .frame_start(fs[0]), .done(dn[0]), .busy(busy[0])
    );

    piso_tx_ctrl #(.WIDTH(4), .GAP(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .sout(sout[1]), .sout_valid(sv[1]),
        .frame_start(fs[1]), .done(dn[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every frame bit, checks idle outputs,
    // gap length and ready-low during the gap, and tracks valid run lengths.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic [2:0] e;
                if (sv[d]) begin
                    if (!prev_sv[d] && gapc[d] != 0) begin
                        chk($sformatf("gap_len[%0d]", d), gapc[d], (d == 1) ? 3 : 0);
                    end
                    if (!prev_sv[d]) gapc[d] = 0;
                    if (q[d].size() == 0) begin
                        chk($sformatf("unexpected_bit[%0d]", d), 1, 0);
                    end else begin
                        e = q[d].pop_front();
                        chk($sformatf("sout[%0d]", d), int'(sout[d]), int'(e[2]));
                        chk($sformatf("frame_start[%0d]", d), int'(fs[d]), int'(e[1]));
                        chk($sformatf("done[%0d]", d), int'(dn[d]), int'(e[0]));
                    end
                    run[d]++;
                end else begin
                    chk($sformatf("idle_outs[%0d]", d), int'({sout[d], fs[d], dn[d]}), 0);
                    if (busy[d]) begin
                        gapc[d]++;
                        chk($sformatf("ready_in_gap[%0d]", d), int'(rdy[d]), 0);
                    end
                    if (run[d] != 0) begin
                        last_run[d] = run[d];
                        run[d] = 0;
                    end
                end
            end
            prev_sv = sv;
        end
    end

    // Offer a word; optionally change din every cycle it is not accepted.
    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input int d, input logic [3:0] w, input bit chg,
                        output int waited, output logic [3:0] acc);
        bit taken;
        din[d] = w;
        dv[d]  = 1'b1;
        waited = 0;
        taken  = 1'b0;
        acc    = 'x;
        for (int i = 0; i < 64 && !taken; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                acc = din[d];
                for (int b = 0; b < 4; b++) begin
                    q[d].push_back({acc[3-b], b == 0, b == 3});
                end
                taken = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!taken) begin
                waited++;
                if (chg) din[d] = chg_tab[i % 4];
            end
        end
        if (!taken) begin
            chk($sformatf("accept_timeout[%0d]", d), 0, 1);
            waited = -1;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        int         w;
        logic [3:0] a;
        chg_tab = '{4'h9, 4'h3, 4'hE, 4'h5};
        for (int d = 0; d < 2; d++) begin
            gapc[d] = 0; run[d] = 0; last_run[d] = 0;
        end
        prev_sv = '0;
        rst_n   = 1'b0;
        din[0]  = 4'b1011;
        din[1]  = 4'b0000;
        dv      = 2'b01;

        // Reset held for three edges with din_valid high.
        cycles(3);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(rdy), 0);
        chk("rst_sout", int'(sout), 0);
        chk("rst_valid", int'(sv), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, accepted on the first edge after release.
        send(0, 4'b1011, 1'b0, w, a);
        chk("first_accept_wait", w, 0);
        dv[0] = 1'b0;
        cycles(6);
        chk("single_run_len", last_run[0], 4);
        chk("single_busy_after", int'(busy[0]), 0);

        // Back-to-back, GAP=0: second word taken on the first word's last bit.
        send(0, 4'b1011, 1'b0, w, a);
        send(0, 4'b0110, 1'b0, w, a);
        chk("b2b_accept_wait", w, 3);
        dv[0] = 1'b0;
        cycles(8);
        chk("b2b_run_len", last_run[0], 8);

        // GAP=3: three gap cycles then one idle cycle before the next accept.
        send(1, 4'b1000, 1'b0, w, a);
        send(1, 4'b0001, 1'b0, w, a);
        chk("gap_accept_wait", w, 7);
        dv[1] = 1'b0;
        cycles(10);
        chk("gap_run_len", last_run[1], 4);
        chk("gap_busy_after", int'(busy[1]), 0);

        // Backpressure with din changing each cycle until accepted.
        send(0, 4'b1011, 1'b0, w, a);
        send(0, 4'b0000, 1'b1, w, a);
        chk("bp_accept_wait", w, 3);
        chk("bp_accept_word", int'(a), int'(4'hE));
        dv[0] = 1'b0;
        cycles(8);

        // Mid-frame reset during the second bit of 4'b1111.
        send(0, 4'b1111, 1'b0, w, a);
        dv[0] = 1'b0;
        cycles(1);
        rst_n = 1'b0;
        cycles(1);
        q[0].delete();
        q[1].delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", int'(sv[0]), 0);
        chk("midrst_done", int'(dn[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        @(posedge clk);
        #1;
        send(0, 4'b0101, 1'b0, w, a);
        chk("post_rst_wait", w, 0);
        dv[0] = 1'b0;
        cycles(8);
        chk("post_rst_run_len", last_run[0], 4);

        chk("sb_empty0", q[0].size(), 0);
        chk("sb_empty1", q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
